cnt_service_arbiter: RTL and testbench

- Shares one increment datapath between two event channels, so both 64-bit counters are updated through a single adder.
- Each channel queues incoming event pulses in a pending counter. A round-robin arbiter services one channel per cycle.
- Channel 1 is prescaled, giving one count per PRESC1 serviced events.
- Sits between the event sources (timers and strobes) and the software-visible counter outputs.

---
 rtl/cnt_service_arbiter.sv | 108 ++++++++++
 tb/tb_cnt_service_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_service_arbiter.sv
// Two event channels sharing one incrementer. Events queue in per-channel pending
// counters and a round-robin arbiter services at most one channel per cycle.
module cnt_service_arbiter #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned PEND_W = 4,
    parameter int unsigned PRESC1 = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Clr0,
    input  logic              Clr1,
    output logic [WIDTH-1:0]  Count0,
    output logic [WIDTH-1:0]  Count1,
    output logic [PEND_W-1:0] Pend0,
    output logic [PEND_W-1:0] Pend1,
    output logic [1:0]        Grant,
    output logic              Drop0,
    output logic              Drop1,
    output logic              Idle
);

    localparam int unsigned       PSC_W    = (PRESC1 > 1) ? $clog2(PRESC1) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(PRESC1 - 1);

    logic [PSC_W-1:0] psc;
    logic             last;
    logic             elig0, elig1;
    logic             sel0, sel1;
    logic             acc0, acc1;
    logic [WIDTH-1:0] inc_sum;

    // Eligibility uses only the pending state before the edge; a cleared channel sits out.
    assign elig0 = En && !Clr0 && (Pend0 != '0);
    assign elig1 = En && !Clr1 && (Pend1 != '0);
    assign sel0  = elig0 && (!elig1 || last);
    assign sel1  = elig1 && (!elig0 || !last);
    assign acc0  = En && !Clr0 && Req0;
    assign acc1  = En && !Clr1 && Req1;

    // The single shared adder: its operand is whichever count the grant targets.
    assign inc_sum = (sel0 ? Count0 : Count1) + WIDTH'(1);

    assign Idle = (Pend0 == '0) && (Pend1 == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count0 <= '0;
            Count1 <= '0;
            Pend0  <= '0;
            Pend1  <= '0;
            psc    <= '0;
            last   <= 1'b1;
            Grant  <= 2'b00;
            Drop0  <= 1'b0;
            Drop1  <= 1'b0;
        end else begin
            Grant <= {sel1, sel0};
            Drop0 <= acc0 && !sel0 && (Pend0 == PEND_MAX);
            Drop1 <= acc1 && !sel1 && (Pend1 == PEND_MAX);

            if (sel0) begin
                last <= 1'b0;
            end else if (sel1) begin
                last <= 1'b1;
            end

            if (Clr0) begin
                Count0 <= '0;
                Pend0  <= '0;
            end else begin
                if (sel0) begin
                    Count0 <= inc_sum;
                end
                if (acc0 && !sel0 && (Pend0 != PEND_MAX)) begin
                    Pend0 <= Pend0 + PEND_W'(1);
                end else if (!acc0 && sel0) begin
                    Pend0 <= Pend0 - PEND_W'(1);
                end
            end

            // Channel 1 only reaches the adder when the prescaler rolls over.
            if (Clr1) begin
                Count1 <= '0;
                Pend1  <= '0;
                psc    <= '0;
            end else begin
                if (sel1) begin
                    if (psc == PSC_LAST) begin
                        psc    <= '0;
                        Count1 <= inc_sum;
                    end else begin
                        psc <= psc + PSC_W'(1);
                    end
                end
                if (acc1 && !sel1 && (Pend1 != PEND_MAX)) begin
                    Pend1 <= Pend1 + PEND_W'(1);
                end else if (!acc1 && sel1) begin
                    Pend1 <= Pend1 - PEND_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_service_arbiter.sv
// Directed bench for cnt_service_arbiter: vector table plus hand-written long sequences.
module tb_cnt_service_arbiter;

    logic        Clk = 1'b0;
    logic        Reset, En, Req0, Req1, Clr0, Clr1;
    logic [63:0] Count0, Count1;
    logic [3:0]  Pend0, Pend1;
    logic [1:0]  Grant;
    logic        Drop0, Drop1, Idle;

    logic [3:0]  n_count0, n_count1;
    logic [3:0]  n_pend0, n_pend1;
    logic [1:0]  n_grant;
    logic        n_drop0, n_drop1, n_idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    cnt_service_arbiter #(.WIDTH(64), .PEND_W(4), .PRESC1(5)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Req0(Req0), .Req1(Req1),
        .Clr0(Clr0), .Clr1(Clr1), .Count0(Count0), .Count1(Count1),
        .Pend0(Pend0), .Pend1(Pend1), .Grant(Grant), .Drop0(Drop0),
        .Drop1(Drop1), .Idle(Idle)
    );

    cnt_service_arbiter #(.WIDTH(4), .PEND_W(4), .PRESC1(5)) dut_narrow (
        .Clk(Clk), .Reset(Reset), .En(En), .Req0(Req0), .Req1(Req1),
        .Clr0(Clr0), .Clr1(Clr1), .Count0(n_count0), .Count1(n_count1),
        .Pend0(n_pend0), .Pend1(n_pend1), .Grant(n_grant), .Drop0(n_drop0),
        .Drop1(n_drop1), .Idle(n_idle)
    );

    typedef struct {
        logic        rst, en, r0, r1, c0, c1;
        logic [63:0] e_c0, e_c1;
        logic [3:0]  e_p0, e_p1;
        logic [1:0]  e_g;
        logic        e_d0, e_d1, e_idle;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, en, r0, r1, c0, c1,
                                input logic [63:0] c0v, c1v, input logic [3:0] p0, p1,
                                input logic [1:0] g, input logic d0, d1, idl);
        vec_t v;
        v.rst = rst; v.en = en; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
        v.e_c0 = c0v; v.e_c1 = c1v; v.e_p0 = p0; v.e_p1 = p1;
        v.e_g = g; v.e_d0 = d0; v.e_d1 = d1; v.e_idle = idl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, en, r0, r1, c0, c1);
        Reset = rst; En = en; Req0 = r0; Req1 = r1; Clr0 = c0; Clr1 = c1;
        @(posedge Clk);
        #1;
    endtask

    int max_p0, max_p1;
    logic [1:0] prev_g;
    logic alt_ok, en0_ok;
    int drained;

    initial begin
        Reset = 1'b1; En = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Clr0 = 1'b0; Clr1 = 1'b0;

        //            rst en r0 r1 c0 c1 | C0 C1 P0 P1 G     D0 D1 Idle
        vecs[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0,   0, 0, 1, 0, 2'b00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2'b01, 0, 0, 1);
        vecs[3]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2'b10, 0, 0, 1);
        vecs[5]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 2'b00, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 1, 2'b10, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 2'b10, 0, 0, 1);
        vecs[10] = mk(0, 1, 1, 0, 0, 0,   1, 1, 1, 0, 2'b00, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 2'b01, 0, 0, 1);
        vecs[12] = mk(0, 1, 1, 0, 0, 0,   2, 1, 1, 0, 2'b00, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 1, 0, 0,   3, 1, 1, 1, 2'b01, 0, 0, 0);
        vecs[14] = mk(0, 1, 1, 1, 0, 0,   3, 1, 2, 1, 2'b10, 0, 0, 0);
        vecs[15] = mk(0, 1, 1, 0, 1, 0,   0, 1, 0, 0, 2'b10, 0, 0, 1);
        vecs[16] = mk(0, 1, 0, 1, 0, 0,   0, 1, 0, 1, 2'b00, 0, 0, 0);
        vecs[17] = mk(0, 1, 1, 1, 0, 1,   0, 0, 1, 0, 2'b00, 0, 0, 0);
        vecs[18] = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2'b01, 0, 0, 1);
        vecs[19] = mk(0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 2'b00, 0, 0, 1);
        vecs[20] = mk(0, 1, 1, 0, 0, 0,   1, 0, 1, 0, 2'b00, 0, 0, 0);
        vecs[21] = mk(0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 2'b00, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1);
        vecs[23] = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].r0, vecs[i].r1, vecs[i].c0, vecs[i].c1);
            chk($sformatf("v%0d.count0", i), Count0, vecs[i].e_c0);
            chk($sformatf("v%0d.count1", i), Count1, vecs[i].e_c1);
            chk($sformatf("v%0d.pend0", i), 64'(Pend0), 64'(vecs[i].e_p0));
            chk($sformatf("v%0d.pend1", i), 64'(Pend1), 64'(vecs[i].e_p1));
            chk($sformatf("v%0d.grant", i), 64'(Grant), 64'(vecs[i].e_g));
            chk($sformatf("v%0d.drop0", i), 64'(Drop0), 64'(vecs[i].e_d0));
            chk($sformatf("v%0d.drop1", i), 64'(Drop1), 64'(vecs[i].e_d1));
            chk($sformatf("v%0d.idle", i), 64'(Idle), 64'(vecs[i].e_idle));
        end

        // Both channels held for 10 edges, then drained.
        step(1, 0, 0, 0, 0, 0);
        max_p0 = 0; max_p1 = 0; prev_g = 2'b00; alt_ok = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 1, 1, 0, 0);
            if (k == 2) chk("both.first_grant", 64'(Grant), 64'(2'b01));
            if (Grant != 2'b00) begin
                if (prev_g != 2'b00 && Grant == prev_g) alt_ok = 1'b0;
                prev_g = Grant;
            end
            if (int'(Pend0) > max_p0) max_p0 = int'(Pend0);
            if (int'(Pend1) > max_p1) max_p1 = int'(Pend1);
            chk($sformatf("both.drop_e%0d", k), 64'({Drop1, Drop0}), 64'(2'b00));
        end
        drained = 0;
        for (int k = 0; k < 40 && drained == 0; k++) begin
            step(0, 1, 0, 0, 0, 0);
            if (Grant != 2'b00) begin
                if (prev_g != 2'b00 && Grant == prev_g) alt_ok = 1'b0;
                prev_g = Grant;
            end
            if (Idle) drained = 1;
        end
        chk("both.drained", 64'(drained), 64'd1);
        chk("both.alternate", 64'(alt_ok), 64'd1);
        chk("both.max_pend0", 64'(max_p0), 64'd5);
        chk("both.max_pend1", 64'(max_p1), 64'd6);
        chk("both.count0", Count0, 64'd10);
        chk("both.count1", Count1, 64'd2);
        chk("both.pend", 64'({Pend1, Pend0}), 64'd0);

        // Prescaler must have been left at 0: five more events yield exactly one count.
        for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("psc.after4", Count1, 64'd2);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("psc.after5", Count1, 64'd3);

        // Requests ignored while disabled.
        step(1, 0, 0, 0, 0, 0);
        en0_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1, 0, 0, 0);
            if (Drop0 || Pend0 != 4'd0 || Grant != 2'b00) en0_ok = 1'b0;
        end
        chk("en0.ignored", 64'(en0_ok), 64'd1);

        // Saturation: both held, each channel serviced on alternate edges.
        for (int k = 1; k <= 40; k++) begin
            logic [3:0] ep0, ep1;
            logic [1:0] eg;
            step(0, 1, 1, 1, 0, 0);
            if (k % 2 == 1) begin
                ep0 = 4'((((k + 1) / 2) > 15) ? 15 : (k + 1) / 2);
                ep1 = 4'((((k + 1) / 2) > 15) ? 15 : (k + 1) / 2);
                eg  = (k == 1) ? 2'b00 : 2'b10;
            end else begin
                ep0 = 4'(((k / 2) > 15) ? 15 : k / 2);
                ep1 = 4'(((k / 2 + 1) > 15) ? 15 : k / 2 + 1);
                eg  = 2'b01;
            end
            chk($sformatf("sat.pend0_e%0d", k), 64'(Pend0), 64'(ep0));
            chk($sformatf("sat.pend1_e%0d", k), 64'(Pend1), 64'(ep1));
            chk($sformatf("sat.grant_e%0d", k), 64'(Grant), 64'(eg));
            chk($sformatf("sat.drop0_e%0d", k), 64'(Drop0), 64'(k >= 31 && k % 2 == 1));
            chk($sformatf("sat.drop1_e%0d", k), 64'(Drop1), 64'(k >= 30 && k % 2 == 0));
        end

        // Narrow instance: Count0 wraps after 16 services.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 1, 1, 0, 0, 0);
        chk("wrap.count0_15", 64'(n_count0), 64'd15);
        chk("wrap.pend0_1", 64'(n_pend0), 64'd1);
        step(0, 1, 0, 0, 0, 0);
        chk("wrap.count0_0", 64'(n_count0), 64'd0);
        chk("wrap.grant", 64'(n_grant), 64'(2'b01));
        chk("wrap.side", 64'({n_count1, n_pend1, n_pend0, n_drop1, n_drop0}), 64'd0);
        chk("wrap.idle", 64'(n_idle), 64'd1);

        // Reset mid-stream overrides live requests.
        for (int k = 0; k < 7; k++) step(0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("rst.count", {Count1[31:0], Count0[31:0]}, 64'd0);
        chk("rst.pend", 64'({Pend1, Pend0}), 64'd0);
        chk("rst.grant_drop", 64'({Grant, Drop1, Drop0}), 64'd0);
        chk("rst.idle", 64'(Idle), 64'd1);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("rst.first_contention", 64'(Grant), 64'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
